kernel_accumulate: RTL

KERNEL_ACCUMULATE -- requirements
Module: kernel_accumulate

---
 rtl/kernel_accumulate_pkg.sv | 16 +
 rtl/kernel_accumulate.sv | 111 +++++++++++
 2 files changed

// File: rtl/kernel_accumulate_pkg.sv
// Shared definitions for the kernel accumulate stage:
// data width, on/off levels and FSM state encodings.
package kernel_accumulate_pkg;

  localparam int BIT_DATA = 8;

  localparam logic OFF = 1'b0;
  localparam logic ON  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/kernel_accumulate.sv
// Saturating multiply-accumulate over one kernel window, with
// early exit once the sum can no longer become positive.
module kernel_accumulate
  import kernel_accumulate_pkg::*;
#(
  parameter int BIT_IN = 16,
  parameter int TAPS   = 9,
  parameter int ET_EN  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BIT_DATA-1:0] a,
  input  logic signed [BIT_DATA-1:0] w,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [BIT_IN-1:0]   y,
  output logic                       terminated
);

  localparam int PW = 2 * BIT_DATA;
  localparam int SW = (BIT_IN > PW ? BIT_IN : PW) + 1;
  localparam int CW = $clog2(TAPS + 1);
  localparam int EW = BIT_IN + $clog2(TAPS) + 1;

  localparam logic signed [BIT_IN-1:0] YMAX =
    {1'b0, {(BIT_IN-1){1'b1}}};
  localparam logic signed [BIT_IN-1:0] YMIN =
    {1'b1, {(BIT_IN-1){1'b0}}};

  state_t state, state_nx;

  logic signed [BIT_IN-1:0] acc, acc_new;
  logic        [CW-1:0]     count, count_new;
  logic signed [PW-1:0]     prod;
  logic signed [SW-1:0]     sum;
  logic        [EW-1:0]     rem, bound;
  logic                     take, last, et, clr;

  assign take = (state == ACC) && in_valid;
  assign prod = PW'(a) * PW'(w);
  assign sum  = SW'(acc) + SW'(prod);

  always_comb begin
    acc_new = sum[BIT_IN-1:0];
    if (sum > SW'(YMAX))
      acc_new = YMAX;
    else if (sum < SW'(YMIN))
      acc_new = YMIN;
  end

  assign count_new = count + CW'(1);
  assign last      = (count_new == CW'(TAPS));

  // Best case: every remaining product is the largest positive one.
  assign rem   = EW'(TAPS) - EW'(count_new);
  assign bound = EW'(acc_new) + (rem << (PW - 2));
  assign et    = (ET_EN != 0) && bound[EW-1];

  assign clr = start &&
    ((state == IDLE) || (state == DONE && out_ready));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = ACC;
      ACC:  if (take && (last || et)) state_nx = DONE;
      DONE: if (out_ready) state_nx = start ? ACC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = OFF;
    out_valid = OFF;
    unique case (state)
      ACC:  in_ready  = ON;
      DONE: out_valid = ON;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      count      <= '0;
      y          <= '0;
      terminated <= OFF;
    end else if (clr) begin
      acc   <= '0;
      count <= '0;
    end else if (take) begin
      acc   <= acc_new;
      count <= count_new;
      if (last || et) begin
        y          <= et ? '0 : acc_new;
        terminated <= et ? ON : OFF;
      end
    end
  end

endmodule
